// File: rtl/serial_add_arbiter.sv
// rtl/serial_add_arbiter.sv - two-requester round-robin front end for a shared bit-serial adder
//
// Purpose:
//   Shares one 1-bit full adder (built from two half adders plus a carry
//   flip-flop) between two requesters. An accepted request is added LSB
//   first over WIDTH cycles, then presented with the winning requester's ID
//   until the consumer takes it.
//
// Parameters:
//   WIDTH      operand/result width in bits (>= 2)
//
// Optional feature macro:
//   SERIAL_ADD_SUB_EN  adds sub0/sub1 inputs; a latched sub bit of 1 turns
//                      the operation into a - b (res_carry = 1 means no borrow)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  [1:0] per-requester request valid
//   req_ready  [1:0] per-requester accept, one-hot or zero
//   a0, b0     requester 0 operands
//   a1, b1     requester 1 operands
//   sub0, sub1 per-requester subtract select (SERIAL_ADD_SUB_EN only)
//   res_valid  result available
//   res_ready  consumer accepts result
//   res_id     requester that owns the result
//   res_sum    sum bits
//   res_carry  carry out of the MSB
module serial_add_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub0,
    input  logic             sub1,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_carry
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic             ptr;
    logic [1:0]       grant;
    logic             accept;
    logic             accept_id;
    logic             last_bit;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             id_q;

    logic             b_bit;
    logic             p;
    logic             g1;
    logic             s;
    logic             g2;

`ifdef SERIAL_ADD_SUB_EN
    logic             sub_q;
    logic             sub_sel;
    assign sub_sel = accept_id ? sub1 : sub0;
    // Subtraction is a + ~b + 1: invert b on the way into the adder, and the
    // +1 comes from presetting the carry at accept.
    assign b_bit   = sb[0] ^ sub_q;
`else
    assign b_bit   = sb[0];
`endif

    // Round-robin grant: a lone requester always wins, a tie goes to ptr.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Gated by rst_n so nothing is offered while reset is held.
    assign req_ready = (rst_n && (state == IDLE)) ? grant : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign accept_id = req_ready[1];
    assign last_bit  = (cnt == CW'(WIDTH - 1));

    // Shared 1-bit datapath: two half adders plus the carry flip-flop.
    assign p  = sa[0] ^ b_bit;
    assign g1 = sa[0] & b_bit;
    assign s  = p ^ c;
    assign g2 = p & c;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ADD;
                end
            end
            ADD: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand/result shift registers, bit counter, carry and arbitration pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            id_q  <= 1'b0;
            ptr   <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            sub_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sa   <= accept_id ? a1 : a0;
                        sb   <= accept_id ? b1 : b0;
                        id_q <= accept_id;
                        cnt  <= '0;
`ifdef SERIAL_ADD_SUB_EN
                        sub_q <= sub_sel;
                        c     <= sub_sel;
`else
                        c     <= 1'b0;
`endif
                    end
                end
                ADD: begin
                    c  <= g1 | g2;
                    // Sum bits enter at the MSB so after WIDTH shifts bit 0
                    // of the result sits at sr[0].
                    sr <= {s, sr[WIDTH-1:1]};
                    sa <= sa >> 1;
                    sb <= sb >> 1;
                    // Hold at WIDTH-1 rather than wrapping when WIDTH is a
                    // power of two.
                    if (!last_bit) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        ptr <= ~id_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign res_valid = (state == DONE);
    assign res_id    = id_q;
    assign res_sum   = sr;
    assign res_carry = c;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// tb/tb_serial_add_arbiter.sv - self-checking bench for serial_add_arbiter
module tb_serial_add_arbiter;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic             sub0, sub1;
    logic             res_valid;
    logic             res_ready;
    logic             res_id;
    logic [WIDTH-1:0] res_sum;
    logic             res_carry;

    int n_checks = 0;
    int n_fail   = 0;
    int mptr     = 0;   // reference round-robin pointer

    serial_add_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
`ifdef SERIAL_ADD_SUB_EN
        .sub0      (sub0),
        .sub1      (sub1),
`endif
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_sum   (res_sum),
        .res_carry (res_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_grant(input logic [1:0] v);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        return mptr;
    endfunction

    // One complete transaction, entered a little after a rising edge with the DUT idle.
    task automatic run_one(input logic [1:0] v, input logic [7:0] x0, input logic [7:0] y0,
                           input logic [7:0] x1, input logic [7:0] y1,
                           input logic s0, input logic s1, input int hold);
        int       g;
        int       a, b, sub;
        int       esum, ecarry;
        logic [7:0] held;
        req_valid = v;
        a0 = x0; b0 = y0; a1 = x1; b1 = y1;
        sub0 = s0; sub1 = s1;
        res_ready = 1'b0;
        #1;
        g = exp_grant(v);
        a = (g == 1) ? int'(x1) : int'(x0);
        b = (g == 1) ? int'(y1) : int'(y0);
`ifdef SERIAL_ADD_SUB_EN
        sub = (g == 1) ? int'(s1) : int'(s0);
`else
        sub = 0;
`endif
        if (sub != 0) begin
            esum   = (a - b) & 255;
            ecarry = (a >= b) ? 1 : 0;
        end else begin
            esum   = (a + b) & 255;
            ecarry = (a + b > 255) ? 1 : 0;
        end
        check("req_ready_grant", 32'(req_ready), (g == 1) ? 32'd2 : 32'd1);
        @(posedge clk); #1;
        check("req_ready_busy", 32'(req_ready), 32'd0);
        check("res_valid_early", 32'(res_valid), 32'd0);
        for (int k = 1; k <= WIDTH; k++) begin
            @(posedge clk); #1;
            check("res_valid_latency", 32'(res_valid), (k == WIDTH) ? 32'd1 : 32'd0);
        end
        check("res_sum", 32'(res_sum), 32'(esum));
        check("res_carry", 32'(res_carry), 32'(ecarry));
        check("res_id", 32'(res_id), 32'(g));
        held = res_sum;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_sum", 32'(res_sum), 32'(held));
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        mptr = 1 - g;
        check("res_valid_drop", 32'(res_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b11;
        a0 = 8'h10; b0 = 8'h20; a1 = 8'h80; b1 = 8'h80;
        sub0 = 1'b0; sub1 = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_sum", 32'(res_sum), 32'd0);
        check("rst_res_carry", 32'(res_carry), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        rst_n = 1'b1;
        mptr = 0;

        // Both requesters held valid from reset: order 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            run_one(2'b11, 8'h10, 8'h20, 8'h80, 8'h80, 1'b0, 1'b0, 0);
            check("rr_order", 32'(res_id), 32'(i % 2));
        end

        run_one(2'b01, 8'h05, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0, 0);
        run_one(2'b10, 8'h00, 8'h00, 8'hFF, 8'h01, 1'b0, 1'b0, 0);
        // Consumer stalls 5 cycles while another request is pending.
        run_one(2'b01, 8'hA5, 8'h3C, 8'h11, 8'h22, 1'b0, 1'b0, 5);

        // Reset during ADD bit 3 aborts the in-flight operation.
        req_valid = 2'b10;
        a1 = 8'h55; b1 = 8'h0F;
        @(posedge clk);
        req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_res_valid", 32'(res_valid), 32'd0);
        check("abort_res_id", 32'(res_id), 32'd0);
        check("abort_res_sum", 32'(res_sum), 32'd0);
        check("abort_res_carry", 32'(res_carry), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mptr = 0;
        #1;
        check("abort_idle_no_result", 32'(res_valid), 32'd0);
        run_one(2'b01, 8'h7F, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 0);

`ifdef SERIAL_ADD_SUB_EN
        run_one(2'b01, 8'h05, 8'h03, 8'h00, 8'h00, 1'b1, 1'b0, 0);
        run_one(2'b01, 8'h03, 8'h05, 8'h00, 8'h00, 1'b1, 1'b0, 0);
        run_one(2'b10, 8'h00, 8'h00, 8'h40, 8'h40, 1'b0, 1'b1, 1);
`endif

        for (int i = 0; i < 24; i++) begin
            run_one(2'($urandom_range(1, 3)),
                    8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        req_valid = 2'b00;
        @(posedge clk); #1;
        check("final_idle_valid", 32'(res_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_add_arbiter.md
# serial_add_arbiter

Bit-serial adder controller that shares a single half-adder-based full-adder cell between two requesters. Each accepted request is added LSB-first over WIDTH cycles through one carry flip-flop and two half adders, and the result is returned with the winning requester's ID. It sits between two operand producers and one result consumer, and replaces two parallel WIDTH-bit adders with one 1-bit datapath plus sequencing.

## Interface
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  2  per-requester request valid; bit i belongs to requester i.
- req_ready  output  2  per-requester accept; one-hot or zero.
- a0, b0  input  WIDTH  requester 0 operands.
- a1, b1  input  WIDTH  requester 1 operands.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_id  output  1  requester that owns the result.
- res_sum  output  WIDTH  sum bits.
- res_carry  output  1  carry out of the MSB.

## Operation
- The FSM has three states: IDLE, ADD and DONE.
- IDLE:
  - req_ready[i] = (state == IDLE) & grant[i].
  - Grant is round-robin. Priority pointer ptr starts at 0 after reset. If only one req_valid bit is set, that requester is granted. If both are set, requester ptr is granted.
  - A handshake (req_valid[i] & req_ready[i]) latches the operands into shift registers sa and sb, latches res_id = i, clears the bit counter and the carry flip-flop, and moves to ADD.
- ADD, one bit per cycle:
  - Half adder 1: p = sa[0]^sb[0], g1 = sa[0]&sb[0].
  - Half adder 2: s = p^c, g2 = p&c.
  - c <= g1 | g2. s shifts into the MSB of the result shift register, and sa and sb shift right.
  - The counter increments each cycle. When the counter reaches WIDTH-1, the FSM moves to DONE.
- DONE:
  - res_valid = 1, res_sum = the result register, res_carry = c.
  - On res_ready, the FSM returns to IDLE and ptr <= ~res_id.
- No request is accepted outside IDLE. req_valid may drop before grant with no side effects.
- Arithmetic: res_sum = (a + b) mod 2^WIDTH; res_carry = bit WIDTH of a + b. The counter is $clog2(WIDTH) bits wide and does not wrap during ADD.

## Timing
- Reset values, applied asynchronously on rst_n low:
  - state = IDLE, ptr = 0.
  - req_ready = 0 while in reset; it then follows the IDLE rule.
  - res_valid = 0, res_id = 0, res_sum = 0, res_carry = 0.
  - Internal registers = 0.
- Latency: with the accept handshake at edge T, res_valid rises after edge T+WIDTH. That is WIDTH+1 cycles from accept to result.
- res_valid and the result fields stay stable until the res_ready handshake.
- req_ready is 0 throughout ADD and DONE.
- Minimum issue interval is WIDTH+2 cycles (accept, WIDTH adds, DONE with res_ready high, then IDLE).
- Simultaneous requests: exactly one is granted per IDLE cycle. The loser keeps req_valid high and is granted on the next IDLE.
- Reset mid-ADD or mid-DONE aborts the operation. The in-flight result is discarded and never presented.

## Configuration
- SERIAL_ADD_SUB_EN:
  - When defined, adds input ports sub0 and sub1 (1 bit each), latched at accept.
  - If the latched sub bit is 1, the b bits are inverted before half adder 1 and c is initialised to 1, giving res_sum = a - b mod 2^WIDTH.
  - In that case res_carry = 1 means no borrow (a ≥ b unsigned).
  - When undefined, there are no sub ports and the block is addition only.

## Test plan
- WIDTH=8, req_valid=01, a0=8'h05, b0=8'h03 -> req_ready=01 for one cycle. res_valid rises 9 cycles after accept with res_sum=8'h08, res_carry=0, res_id=0.
- a1=8'hFF, b1=8'h01 via requester 1 alone -> res_sum=8'h00, res_carry=1, res_id=1.
- Both req_valid=11 held from reset, res_ready=1:
  - Results arrive in order id 0, 1, 0, 1.
  - a0+b0=8'h10+8'h20 gives 8'h30; a1+b1=8'h80+8'h80 gives 8'h00 with carry 1.
- res_ready=0 for 5 cycles in DONE -> res_valid and res_sum held stable, req_ready stays 00 despite a pending request, then completes on res_ready=1.
- rst_n low for one cycle at ADD bit 3 -> all outputs go to 0 immediately and state is IDLE. A following request 8'h7F+8'h01 gives 8'h80, carry 0, with normal latency.
- With SERIAL_ADD_SUB_EN defined:
  - sub0=1, 8'h05-8'h03 -> 8'h02, res_carry=1.
  - 8'h03-8'h05 -> 8'hFE, res_carry=0.
